// File: rtl/core_quant_mc_pkg.sv
// rtl/core_quant_mc_pkg.sv - shared encodings and default widths for the quantiser
package core_quant_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_RSVD      = 2'd3
  } rnd_mode_e;

  localparam int DEF_LANES       = 4;
  localparam int DEF_IDATA_WIDTH = 24;
  localparam int DEF_ODATA_BIT   = 8;
  localparam int DEF_SCALE_WIDTH = 16;
  localparam int DEF_BIAS_WIDTH  = 16;
  localparam int DEF_SHIFT_WIDTH = 5;
  localparam int DEF_NUM_CH      = 64;
  localparam int DEF_MUL_STAGES  = 2;
  localparam int SAT_CNT_W       = 16;

endpackage

// File: rtl/core_quant_mc_if.sv
// rtl/core_quant_mc_if.sv - input/output beat handshake bundle
interface core_quant_mc_if
  import core_quant_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int IDATA_WIDTH = DEF_IDATA_WIDTH,
  parameter int ODATA_BIT   = DEF_ODATA_BIT
);
  logic [LANES*IDATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic [LANES*ODATA_BIT-1:0]   out_data;
  logic                         out_valid;
  logic                         out_last;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/core_quant_mc_lane.sv
// rtl/core_quant_mc_lane.sv - one lane: multiply, bias, shift, round, clip
module core_quant_lane
  import core_quant_pkg::*;
#(
  parameter int IDATA_WIDTH = DEF_IDATA_WIDTH,
  parameter int ODATA_BIT   = DEF_ODATA_BIT,
  parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int BIAS_WIDTH  = DEF_BIAS_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int MUL_STAGES  = DEF_MUL_STAGES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   adv,
  input  logic [IDATA_WIDTH-1:0] data,
  input  logic [SCALE_WIDTH-1:0] scale,
  input  logic [BIAS_WIDTH-1:0]  bias,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [1:0]             rnd_mode,
  input  logic                   sym_clip,
  output logic [ODATA_BIT-1:0]   q,
  output logic                   sat
);
  localparam int PW   = IDATA_WIDTH + SCALE_WIDTH;
  localparam int BW   = PW + 1;
  localparam int RW   = BW + 1;
  localparam int MAXI = (1 << (ODATA_BIT - 1)) - 1;
  localparam int LS   = MUL_STAGES - 1;

  logic signed [PW-1:0]  prod   [MUL_STAGES];
  logic [BIAS_WIDTH-1:0] bias_p [MUL_STAGES];
  logic [SHIFT_WIDTH-1:0] sh_p  [MUL_STAGES];
  logic [1:0]            mode_p [MUL_STAGES];
  logic                  sym_p  [MUL_STAGES];

  // Extra stages just delay the product so the tool can retime the multiplier.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod[i] <= '0; bias_p[i] <= '0; sh_p[i] <= '0; mode_p[i] <= '0; sym_p[i] <= 1'b0;
      end
    end else if (adv) begin
      prod[0]   <= $signed({{(PW-IDATA_WIDTH){data[IDATA_WIDTH-1]}}, data})
                 * $signed({{(PW-SCALE_WIDTH){1'b0}}, scale});
      bias_p[0] <= bias;
      sh_p[0]   <= shift;
      mode_p[0] <= rnd_mode;
      sym_p[0]  <= sym_clip;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod[i] <= prod[i-1]; bias_p[i] <= bias_p[i-1]; sh_p[i] <= sh_p[i-1];
        mode_p[i] <= mode_p[i-1]; sym_p[i] <= sym_p[i-1];
      end
    end
  end

  logic signed [BW-1:0] b, s;
  logic [BW-1:0]        low_mask, g_mask;
  logic                 g, r, inc;
  logic signed [RW-1:0] rnd, rnd_r;
  logic                 sym_r;

  // low_mask covers the shifted-out bits; its top bit is the guard bit.
  always_comb begin
    b        = $signed({prod[LS][PW-1], prod[LS]})
             + $signed({{(BW-BIAS_WIDTH){bias_p[LS][BIAS_WIDTH-1]}}, bias_p[LS]});
    s        = b >>> sh_p[LS];
    low_mask = (BW'(1) << sh_p[LS]) - BW'(1);
    g_mask   = low_mask & ~(low_mask >> 1);
    g        = |(b & g_mask);
    r        = |(b & (low_mask >> 1));
    case (mode_p[LS])
      RND_TRUNC:     inc = 1'b0;
      RND_HALF_EVEN: inc = g & (r | s[0]);
      default:       inc = g;
    endcase
    rnd = {s[BW-1], s} + RW'(inc);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rnd_r <= '0;
      sym_r <= 1'b0;
    end else if (adv) begin
      rnd_r <= rnd;
      sym_r <= sym_p[LS];
    end
  end

  logic signed [RW-1:0] maxv, minv, clipped;
  logic                 hit;

  always_comb begin
    maxv    = RW'(MAXI);
    minv    = sym_r ? -maxv : ~maxv;
    clipped = rnd_r;
    hit     = 1'b0;
    if (rnd_r > maxv) begin
      clipped = maxv;
      hit     = 1'b1;
    end else if (rnd_r < minv) begin
      clipped = minv;
      hit     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (adv) begin
      q   <= clipped[ODATA_BIT-1:0];
      sat <= hit;
    end
  end
endmodule

// File: rtl/core_quant_mc.sv
// rtl/core_quant_mc.sv - multi-channel requantiser: per-channel table, lanes, handshake
module core_quant_mc
  import core_quant_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int IDATA_WIDTH = DEF_IDATA_WIDTH,
  parameter int ODATA_BIT   = DEF_ODATA_BIT,
  parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int BIAS_WIDTH  = DEF_BIAS_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int MUL_STAGES  = DEF_MUL_STAGES
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [SCALE_WIDTH-1:0]    cfg_scale,
  input  logic [BIAS_WIDTH-1:0]     cfg_bias,
  input  logic [SHIFT_WIDTH-1:0]    cfg_shift,
  input  logic [$clog2(NUM_CH):0]   cfg_ch_num,
  input  logic [1:0]                cfg_rnd_mode,
  input  logic                      cfg_sym_clip,
  input  logic                      sat_clr,
  output logic [SAT_CNT_W-1:0]      sat_cnt,
  core_quant_mc_if.slave            bus
);
  localparam int AW = $clog2(NUM_CH);
  localparam int L  = MUL_STAGES + 3;

  logic adv, accept;
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign accept       = bus.in_valid & adv;
  assign bus.in_ready = adv;

  logic [SCALE_WIDTH-1:0] scale_t [NUM_CH];
  logic [BIAS_WIDTH-1:0]  bias_t  [NUM_CH];
  logic [SHIFT_WIDTH-1:0] shift_t [NUM_CH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_t[i] <= SCALE_WIDTH'(1);
        bias_t[i]  <= '0;
        shift_t[i] <= '0;
      end
    end else if (cfg_we) begin
      scale_t[cfg_addr] <= cfg_scale;
      bias_t[cfg_addr]  <= cfg_bias;
      shift_t[cfg_addr] <= cfg_shift;
    end
  end

  logic [AW-1:0] ch_base;
  logic [AW:0]   ch_next;
  assign ch_next = {1'b0, ch_base} + (AW+1)'(LANES);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ch_base <= '0;
    else if (accept)
      ch_base <= (bus.in_last || ch_next >= cfg_ch_num) ? '0 : ch_next[AW-1:0];
  end

  logic [1:0]   mode0;
  logic         sym0;
  logic [L-1:0] vld, lst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode0 <= '0;
      sym0  <= 1'b0;
      vld   <= '0;
      lst   <= '0;
    end else if (adv) begin
      mode0 <= cfg_rnd_mode;
      sym0  <= cfg_sym_clip;
      vld   <= {vld[L-2:0], bus.in_valid};
      lst   <= {lst[L-2:0], bus.in_last};
    end
  end

  assign bus.out_valid = vld[L-1];
  assign bus.out_last  = lst[L-1];

  logic [LANES*ODATA_BIT-1:0] out_vec;
  logic [LANES-1:0]           sat_vec;

  // Table reads happen in the accept cycle, so later writes never reach an in-flight beat.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [AW-1:0]          idx;
    logic [IDATA_WIDTH-1:0] d0;
    logic [SCALE_WIDTH-1:0] sc0;
    logic [BIAS_WIDTH-1:0]  bi0;
    logic [SHIFT_WIDTH-1:0] sh0;

    assign idx = ch_base + AW'(l);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        d0 <= '0; sc0 <= '0; bi0 <= '0; sh0 <= '0;
      end else if (adv) begin
        d0  <= bus.in_data[l*IDATA_WIDTH +: IDATA_WIDTH];
        sc0 <= scale_t[idx];
        bi0 <= bias_t[idx];
        sh0 <= shift_t[idx];
      end
    end

    core_quant_lane #(
      .IDATA_WIDTH(IDATA_WIDTH), .ODATA_BIT(ODATA_BIT), .SCALE_WIDTH(SCALE_WIDTH),
      .BIAS_WIDTH(BIAS_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .MUL_STAGES(MUL_STAGES)
    ) u_lane (
      .clk(clk), .rstn(rstn), .adv(adv), .data(d0), .scale(sc0), .bias(bi0),
      .shift(sh0), .rnd_mode(mode0), .sym_clip(sym0),
      .q(out_vec[l*ODATA_BIT +: ODATA_BIT]), .sat(sat_vec[l])
    );
  end

  assign bus.out_data = out_vec;

  logic [SAT_CNT_W:0] nsat, sum;
  always_comb begin
    nsat = '0;
    for (int l = 0; l < LANES; l++) nsat = nsat + (SAT_CNT_W+1)'(sat_vec[l]);
    sum = {1'b0, sat_cnt} + nsat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (bus.out_valid && bus.out_ready)
      sat_cnt <= sum[SAT_CNT_W] ? '1 : sum[SAT_CNT_W-1:0];
  end
endmodule

// File: tb/tb_core_quant_mc.sv
// tb/tb_core_quant_mc.sv - self-checking bench for core_quant_mc
module tb_core_quant_mc;
  import core_quant_pkg::*;

  localparam int LANES = 2, IW = 24, OB = 8, NUM_CH = 8, MS = 2, LAT = MS + 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        cfg_we, cfg_sym_clip, sat_clr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_scale, cfg_bias, sat_cnt;
  logic [4:0]  cfg_shift;
  logic [3:0]  cfg_ch_num;
  logic [1:0]  cfg_rnd_mode;

  core_quant_mc_if #(.LANES(LANES), .IDATA_WIDTH(IW), .ODATA_BIT(OB)) bus ();

  core_quant_mc #(
    .LANES(LANES), .IDATA_WIDTH(IW), .ODATA_BIT(OB), .SCALE_WIDTH(16), .BIAS_WIDTH(16),
    .SHIFT_WIDTH(5), .NUM_CH(NUM_CH), .MUL_STAGES(MS)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_ch_num(cfg_ch_num),
    .cfg_rnd_mode(cfg_rnd_mode), .cfg_sym_clip(cfg_sym_clip), .sat_clr(sat_clr),
    .sat_cnt(sat_cnt), .bus(bus)
  );

  typedef struct {
    logic [LANES*OB-1:0] data;
    logic                last;
    int                  nsat;
  } beat_t;

  typedef struct {
    int idata;
    int mode;
    bit sym;
    int sh;
    int expv;
  } vec_t;

  longint m_scale [NUM_CH];
  longint m_bias  [NUM_CH];
  int     m_shift [NUM_CH];
  int     m_base, m_sat;
  beat_t  exp_q[$];
  beat_t  got_q[$];
  int     n_chk = 0, n_fail = 0;
  bit     smp_acc, smp_in_ready, smp_out_valid;

  task automatic chk(input bit ok, input string name, input longint got, input longint expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, expv);
    end
  endtask

  // Reference: exact integer arithmetic, floor-shift, remainder-based rounding, clip.
  function automatic longint quant(input longint x, input int sh, input int mode,
                                   input bit sym, output bit clip);
    longint q, rem, half, mx, mn;
    q = x;
    if (sh > 0) begin
      q    = x >>> sh;
      rem  = x - (q <<< sh);
      half = longint'(1) <<< (sh - 1);
      if (mode == 1 || mode == 3) begin
        if (rem >= half) q++;
      end else if (mode == 2) begin
        if (rem > half || (rem == half && q[0])) q++;
      end
    end
    mx   = (longint'(1) <<< (OB - 1)) - 1;
    mn   = sym ? -mx : -mx - 1;
    clip = 1'b0;
    if (q > mx) begin q = mx; clip = 1'b1; end
    else if (q < mn) begin q = mn; clip = 1'b1; end
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_scale[i] = 1; m_bias[i] = 0; m_shift[i] = 0;
    end
    m_base = 0;
    m_sat  = 0;
    exp_q.delete();
  endtask

  task automatic step();
    beat_t e, g;
    bit c;
    longint x, v, rv;
    int ch;
    @(negedge clk);
    smp_acc       = bus.in_valid && bus.in_ready;
    smp_in_ready  = bus.in_ready;
    smp_out_valid = bus.out_valid;
    chk(sat_cnt == 16'(m_sat), "sat_cnt", sat_cnt, m_sat);
    if (bus.out_valid && bus.out_ready) begin
      g.data = bus.out_data; g.last = bus.out_last; g.nsat = 0;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", g.data, 0);
        if (sat_clr) m_sat = 0;
      end else begin
        e = exp_q.pop_front();
        chk(g.data == e.data && g.last == e.last, "beat", {g.last, g.data}, {e.last, e.data});
        m_sat = sat_clr ? 0 : ((m_sat + e.nsat > 65535) ? 65535 : m_sat + e.nsat);
      end
    end else if (sat_clr) m_sat = 0;
    if (smp_acc) begin
      e.last = bus.in_last; e.nsat = 0; e.data = '0;
      for (int l = 0; l < LANES; l++) begin
        ch = (m_base + l) % NUM_CH;
        x  = longint'($signed(bus.in_data[l*IW +: IW]));
        v  = m_scale[ch] * x + m_bias[ch];
        rv = quant(v, m_shift[ch], int'(cfg_rnd_mode), cfg_sym_clip, c);
        e.data[l*OB +: OB] = rv[OB-1:0];
        e.nsat += int'(c);
      end
      exp_q.push_back(e);
      m_base += LANES;
      if (bus.in_last || m_base >= int'(cfg_ch_num)) m_base = 0;
    end
    if (cfg_we) begin
      m_scale[cfg_addr] = longint'(cfg_scale);
      m_bias[cfg_addr]  = longint'($signed(cfg_bias));
      m_shift[cfg_addr] = int'(cfg_shift);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int sc, input int bi, input int sh);
    cfg_addr = 3'(a); cfg_scale = 16'(sc); cfg_bias = 16'(bi); cfg_shift = 5'(sh);
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [LANES*IW-1:0] d, input bit last);
    int n = 0;
    bus.in_data = d; bus.in_last = last; bus.in_valid = 1'b1;
    do begin step(); n++; end while (!smp_acc && n < 50);
    if (!smp_acc) chk(1'b0, "send_timeout", n, 50);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin step(); n++; end
    if (exp_q.size() > 0) chk(1'b0, "drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_got(input int i, input logic [15:0] d, input bit last, input string name);
    if (i >= got_q.size()) chk(1'b0, name, got_q.size(), i + 1);
    else chk(got_q[i].data == d && got_q[i].last == last, name,
             {got_q[i].last, got_q[i].data}, {last, d});
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    cfg_we = 1'b0; sat_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  vec_t vecs[9];
  logic [IW-1:0] dv;
  logic [OB-1:0] ev;
  logic [LANES*IW-1:0] ones;
  int n, sent, cyc;

  initial begin
    vecs[0] = '{10, 0, 0, 2, 2};     vecs[1] = '{10, 1, 0, 2, 3};
    vecs[2] = '{10, 2, 0, 2, 2};     vecs[3] = '{-10, 0, 0, 2, -3};
    vecs[4] = '{-10, 1, 0, 2, -2};   vecs[5] = '{-10, 2, 0, 2, -2};
    vecs[6] = '{1000, 0, 0, 0, 127}; vecs[7] = '{-1000, 0, 0, 0, -128};
    vecs[8] = '{-1000, 0, 1, 0, -127};
    ones = {24'd1, 24'd1};
    cfg_addr = '0; cfg_scale = '0; cfg_bias = '0; cfg_shift = '0;
    cfg_ch_num = 4'd2; cfg_rnd_mode = 2'd0; cfg_sym_clip = 1'b0;
    do_reset();

    chk(bus.out_valid == 1'b0, "reset_out_valid", bus.out_valid, 0);
    chk(bus.out_last == 1'b0, "reset_out_last", bus.out_last, 0);
    chk(bus.out_data == '0, "reset_out_data", bus.out_data, 0);
    chk(sat_cnt == 16'd0, "reset_sat_cnt", sat_cnt, 0);
    chk(bus.in_ready == 1'b1, "reset_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      cfg_rnd_mode = 2'(vecs[i].mode);
      cfg_sym_clip = vecs[i].sym;
      cfg_write(0, 1, 0, vecs[i].sh);
      cfg_write(1, 1, 0, vecs[i].sh);
      got_q.delete();
      dv = IW'(vecs[i].idata);
      send({dv, dv}, 1'b0);
      n = 0;
      while (got_q.size() == 0 && n < 20) begin step(); n++; end
      chk(n == LAT, "latency", n, LAT);
      ev = OB'(vecs[i].expv);
      chk_got(0, {ev, ev}, 1'b0, "vector");
    end
    chk(sat_cnt == 16'd6, "sat_cnt_after_clip", sat_cnt, 6);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk(sat_cnt == 16'd0, "sat_clr", sat_cnt, 0);

    cfg_rnd_mode = 2'd0; cfg_sym_clip = 1'b0; cfg_ch_num = 4'd4;
    for (int k = 0; k < 4; k++) cfg_write(k, k + 1, 0, 0);
    got_q.delete();
    repeat (3) send(ones, 1'b0);
    drain();
    chk_got(0, 16'h0201, 1'b0, "ch_beat0");
    chk_got(1, 16'h0403, 1'b0, "ch_beat1");
    chk_got(2, 16'h0201, 1'b0, "ch_beat2");
    got_q.delete();
    send(ones, 1'b0);
    send(ones, 1'b1);
    send(ones, 1'b0);
    drain();
    chk_got(0, 16'h0403, 1'b0, "last_beat0");
    chk_got(1, 16'h0201, 1'b1, "last_beat1");
    chk_got(2, 16'h0201, 1'b0, "last_beat2");

    got_q.delete();
    sent = 0; cyc = 0;
    bus.in_data = {24'($urandom_range(0, 200) - 100), 24'($urandom_range(0, 200) - 100)};
    while ((sent < 10 || exp_q.size() > 0) && cyc < 100) begin
      bus.in_valid  = (sent < 10);
      bus.out_ready = !(cyc >= 3 && cyc <= 7);
      step();
      if (smp_acc) begin
        sent++;
        bus.in_data = {24'($urandom_range(0, 200) - 100), 24'($urandom_range(0, 200) - 100)};
      end
      if (cyc == 6) begin
        chk(smp_in_ready == 1'b0, "stall_in_ready", smp_in_ready, 0);
        chk(smp_out_valid == 1'b1, "stall_out_valid", smp_out_valid, 1);
      end
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk(got_q.size() == 10, "stall_count", got_q.size(), 10);

    bus.out_ready = 1'b0;
    repeat (3) send(ones, 1'b0);
    n = 0;
    while (!smp_out_valid && n < 10) begin step(); n++; end
    chk(smp_out_valid == 1'b1, "pre_reset_valid", smp_out_valid, 1);
    rstn = 1'b0;
    #1;
    chk(bus.out_valid == 1'b0, "async_reset_valid", bus.out_valid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.out_ready = 1'b1;
    got_q.delete();
    step();
    chk(smp_in_ready == 1'b1, "ready_after_release", smp_in_ready, 1);
    repeat (10) step();
    chk(got_q.size() == 0, "no_stale_beat", got_q.size(), 0);

    for (int rd = 0; rd < 4; rd++) begin
      cfg_ch_num   = 4'(2 * $urandom_range(1, 4));
      cfg_rnd_mode = 2'($urandom_range(0, 3));
      cfg_sym_clip = 1'($urandom_range(0, 1));
      for (int k = 0; k < NUM_CH; k++)
        cfg_write(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 8),
                  $urandom_range(0, 65535), $urandom_range(0, 12));
      for (int c = 0; c < 150; c++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_last   = ($urandom_range(0, 9) == 0);
        bus.out_ready = ($urandom_range(0, 9) < 7);
        sat_clr       = ($urandom_range(0, 19) == 0);
        for (int l = 0; l < LANES; l++)
          bus.in_data[l*IW +: IW] = $urandom_range(0, 1) ? 24'($urandom())
                                                          : 24'($urandom_range(0, 2000) - 1000);
        cfg_we    = ($urandom_range(0, 19) == 0);
        cfg_addr  = 3'($urandom_range(0, NUM_CH - 1));
        cfg_scale = 16'($urandom_range(0, 8));
        cfg_bias  = 16'($urandom());
        cfg_shift = 5'($urandom_range(0, 31));
        step();
      end
      cfg_we = 1'b0; sat_clr = 1'b0; bus.in_last = 1'b0;
      drain();
    end
    chk(sat_cnt == 16'(m_sat), "final_sat_cnt", sat_cnt, m_sat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core_quant_mc.md
CORE_QUANT_MC -- requirements
Module: core_quant_mc

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LANES, 4, parallel data lanes per beat.
- IDATA_WIDTH, 24, signed input width per lane.
- ODATA_BIT, 8, signed output width per lane.
- SCALE_WIDTH, 16, unsigned scale width.
- BIAS_WIDTH, 16, signed bias width.
- SHIFT_WIDTH, 5, shift amount width.
- NUM_CH, 64, per-channel parameter table depth; multiple of LANES.
- MUL_STAGES, 2, multiplier pipeline stages, >=1.
REQ-002 Ports SHALL be (name, direction, width, meaning); reset is rstn, asynchronous, active-low; clock is clk:
- clk, in, 1, clock.
- rstn, in, 1, async active-low reset.
- cfg_we, in, 1, table write strobe.
- cfg_addr, in, clog2(NUM_CH), table entry.
- cfg_scale / cfg_bias / cfg_shift, in, SCALE/BIAS/SHIFT_WIDTH, entry contents.
- cfg_ch_num, in, clog2(NUM_CH)+1, active channels; multiple of LANES.
- cfg_rnd_mode, in, 2, 0 truncate, 1 half-up, 2 half-even, 3 reserved (acts as 1).
- cfg_sym_clip, in, 1, symmetric clip.
- in_data, in, LANES*IDATA_WIDTH, lane l at [l*IDATA_WIDTH +: IDATA_WIDTH].
- in_valid / in_last / in_ready, in/in/out, 1, input handshake; in_last marks end of vector.
- out_data, out, LANES*ODATA_BIT, quantised lanes.
- out_valid / out_last / out_ready, out/out/in, 1, output handshake.
- sat_clr, in, 1, clears sat_cnt.
- sat_cnt, out, 16, saturated-lane counter.

Function
REQ-003 Beat SHALL transfer when valid&ready, on both sides.
REQ-004 Pipeline SHALL advance globally on adv = out_ready | ~out_valid; in_ready = adv; stalled stages hold data.
REQ-005 Latency in_accept -> out_valid SHALL be MUL_STAGES+3 cycles with out_ready held high; one beat per cycle sustained.
REQ-006 Channel base counter ch_base SHALL start at 0; lane l uses table entry ch_base+l; on accept, ch_base += LANES, wrapping to 0 when the result >= cfg_ch_num or when in_last=1.
REQ-007 Table parameters SHALL be read at acceptance and travel with the beat; a cfg_we write affects only beats accepted after the write cycle.
REQ-008 Per lane: p = signed(idata)*unsigned(scale), width IDATA_WIDTH+SCALE_WIDTH; b = p + sign-extended bias, one extra bit; s = b >>> shift (arithmetic).
REQ-009 Rounding with shift=0 SHALL add 0; else g = b[shift-1], r = |b[shift-2:0]:
- mode 0: add 0.
- mode 1 and 3: add g.
- mode 2: add g&(r|s[0]).
REQ-010 Saturation SHALL clip to max = 2^(ODATA_BIT-1)-1 and min = -2^(ODATA_BIT-1), or -(2^(ODATA_BIT-1)-1) when cfg_sym_clip=1.
REQ-011 sat_cnt SHALL add the number of clipped lanes of each beat at output transfer, stick at 0xFFFF, and zero on sat_clr; sat_clr wins over a same-cycle increment.
REQ-012 out_last SHALL be in_last delayed with its beat; beat order SHALL be preserved.

Reset
REQ-013 On rstn low, all of the following SHALL be 0 asynchronously: out_valid, out_last, out_data, sat_cnt, ch_base, pipeline valid bits.
REQ-014 The parameter table SHALL reset to scale=1, bias=0, shift=0.
REQ-015 Reset mid-stream SHALL discard in-flight beats; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-016 Package core_quant_pkg SHALL hold the round-mode encodings, default widths, and the sat_cnt width.
REQ-017 Per-lane arithmetic SHALL be a sub-module core_quant_lane, instantiated LANES times; ch_base, the table and the handshake SHALL stay in the top module.

Verification
REQ-018 Bench SHALL cover the following with LANES=2, ODATA_BIT=8, scale=1, bias=0, shift=2:
- idata=10 -> 2 (mode 0), 3 (mode 1), 2 (mode 2).
- idata=-10 -> -3 (mode 0), -2 (mode 1), -2 (mode 2).
REQ-019 shift=0, idata=1000 -> 127; idata=-1000 -> -128, or -127 with sym_clip; sat_cnt increments by 2 per beat; sat_clr -> 0.
REQ-020 cfg_ch_num=4 with scales {1,2,3,4}, idata all 1, 3 beats -> outputs {1,2},{3,4},{1,2}; in_last on beat 1 -> beat 2 outputs {1,2}.
REQ-021 Stream 10 beats, out_ready low for cycles 3-7 -> no loss or duplication, order kept, in_ready low while stalled and full.
REQ-022 rstn pulsed low with 3 beats in flight -> out_valid 0 immediately, no stale beat emitted after release.
